// File: rtl/audio_sample_ctrl.sv
// Codec frame sequencer: ADC capture -> processor handshake -> DAC write, with timeout and overrun drop counting.
// Optional BYPASS passthrough is compiled in when AUDIO_PASSTHRU_EN is defined.
module audio_sample_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AUD_INIT_FINISH,
  input  logic              AUD_ADC_FULL,
  input  logic [DATA_W-1:0] ADCDATA,
  input  logic              AUD_DAC_FULL,
  output logic [DATA_W-1:0] DACDATA,
  output logic              AUD_DATA_OVER,
  output logic [DATA_W-1:0] SAMPLE_OUT,
  output logic              SAMPLE_VALID,
  input  logic              SAMPLE_READY,
  input  logic [DATA_W-1:0] PROC_DATA,
  input  logic              PROC_VALID,
  output logic              PROC_READY,
`ifdef AUDIO_PASSTHRU_EN
  input  logic              BYPASS,
`endif
  output logic [15:0]       DROP_CNT
);

  // state      | meaning
  // ST_INIT    | codec not initialised, nothing captured
  // ST_IDLE    | waiting for a new ADC sample
  // ST_PRESENT | sample offered to the processor (SAMPLE_VALID)
  // ST_WAIT_PROC | waiting for the processed result (PROC_READY)
  // ST_WRITE   | waiting for the DAC to be free, then load and release the frame
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRESENT,
    ST_WAIT_PROC,
    ST_WRITE
  } state_t;

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  state_t                          state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0]     sync_q, sync_d;
  logic                            adc_prev_q, adc_prev_d;
  logic                            adc_rise_q, adc_rise_d;
  logic [TMR_W-1:0]                tmr_q, tmr_d;
  logic [DATA_W-1:0]               sample_q, sample_d;
  logic [DATA_W-1:0]               proc_q, proc_d;
  logic [DATA_W-1:0]               dac_q, dac_d;
  logic                            sample_valid_q, sample_valid_d;
  logic                            proc_ready_q, proc_ready_d;
  logic                            over_q, over_d;
  logic [15:0]                     drop_q, drop_d;
  logic [1:0]                      drop_inc;
  logic [16:0]                     drop_sum;
  logic                            init_ok, adc_lvl, dac_busy, bypass;
  logic                            tmr_tc, sample_hs, proc_hs;

`ifdef AUDIO_PASSTHRU_EN
  assign bypass = BYPASS;
`else
  assign bypass = 1'b0;
`endif

  assign init_ok  = sync_q[SYNC_STAGES-1][0];
  assign adc_lvl  = sync_q[SYNC_STAGES-1][1];
  assign dac_busy = sync_q[SYNC_STAGES-1][2];

  always_comb begin
    sync_d[0] = {AUD_DAC_FULL, AUD_ADC_FULL, AUD_INIT_FINISH};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    state_d    = state_q;
    sample_d   = sample_q;
    proc_d     = proc_q;
    dac_d      = dac_q;
    tmr_d      = tmr_q;
    over_d     = 1'b0;
    drop_inc   = 2'd0;
    adc_prev_d = adc_lvl;
    adc_rise_d = adc_lvl & ~adc_prev_q;
    sample_hs  = sample_valid_q & SAMPLE_READY;
    proc_hs    = proc_ready_q & PROC_VALID;
    tmr_tc     = (tmr_q == '0);

    if (!init_ok) begin
      state_d = ST_INIT;
    end else begin
      // a new sample while a frame is in flight is lost, the frame carries on
      if (adc_rise_q && state_q != ST_IDLE && state_q != ST_INIT) drop_inc = 2'd1;
      case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_IDLE: begin
          if (adc_rise_q) begin
            sample_d = ADCDATA;
            if (bypass) begin
              proc_d  = ADCDATA;
              state_d = ST_WRITE;
            end else begin
              tmr_d   = TMR_LOAD;
              state_d = ST_PRESENT;
            end
          end
        end
        ST_PRESENT: begin
          if (sample_hs) begin
            tmr_d   = TMR_LOAD;
            state_d = ST_WAIT_PROC;
          end else if (tmr_tc) begin
            drop_inc = drop_inc + 2'd1;
            over_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ST_WAIT_PROC: begin
          if (proc_hs) begin
            proc_d  = PROC_DATA;
            state_d = ST_WRITE;
          end else if (tmr_tc) begin
            drop_inc = drop_inc + 2'd1;
            over_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ST_WRITE: begin
          if (!dac_busy) begin
            dac_d   = proc_q;
            over_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    drop_sum       = {1'b0, drop_q} + {15'd0, drop_inc};
    drop_d         = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    sample_valid_d = (state_d == ST_PRESENT);
    proc_ready_d   = (state_d == ST_WAIT_PROC);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_INIT;
      sync_q         <= '0;
      adc_prev_q     <= 1'b0;
      adc_rise_q     <= 1'b0;
      tmr_q          <= '0;
      sample_q       <= '0;
      proc_q         <= '0;
      dac_q          <= '0;
      sample_valid_q <= 1'b0;
      proc_ready_q   <= 1'b0;
      over_q         <= 1'b0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      adc_prev_q     <= adc_prev_d;
      adc_rise_q     <= adc_rise_d;
      tmr_q          <= tmr_d;
      sample_q       <= sample_d;
      proc_q         <= proc_d;
      dac_q          <= dac_d;
      sample_valid_q <= sample_valid_d;
      proc_ready_q   <= proc_ready_d;
      over_q         <= over_d;
      drop_q         <= drop_d;
    end
  end

  assign DACDATA       = dac_q;
  assign AUD_DATA_OVER = over_q;
  assign SAMPLE_OUT    = sample_q;
  assign SAMPLE_VALID  = sample_valid_q;
  assign PROC_READY    = proc_ready_q;
  assign DROP_CNT      = drop_q;

endmodule

// File: tb/tb_audio_sample_ctrl.sv
// Self-checking bench for audio_sample_ctrl: directed frame scenarios plus randomized frames vs. an outcome model.
`timescale 1ns/1ps
module tb_audio_sample_ctrl;
  localparam int W = 32;
  localparam int S = 2;
  localparam int T = 256;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          init_fin = 1'b0, adc_full = 1'b0, dac_full = 1'b0;
  logic          s_ready = 1'b0, p_valid = 1'b0;
  logic [W-1:0]  adc_data = '0, proc_data = '0;
  logic [W-1:0]  dac_out, sample_out;
  logic          data_over, s_valid, p_ready;
  logic [15:0]   drop_cnt;
`ifdef AUDIO_PASSTHRU_EN
  logic          bypass = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  logic [15:0]  exp_drop = 16'd0;
  logic [W-1:0] exp_dac = '0;

  audio_sample_ctrl #(.DATA_W(W), .SYNC_STAGES(S), .TIMEOUT_CYC(T)) dut (
    .Clk(Clk), .Reset(Reset), .AUD_INIT_FINISH(init_fin), .AUD_ADC_FULL(adc_full),
    .ADCDATA(adc_data), .AUD_DAC_FULL(dac_full), .DACDATA(dac_out), .AUD_DATA_OVER(data_over),
    .SAMPLE_OUT(sample_out), .SAMPLE_VALID(s_valid), .SAMPLE_READY(s_ready),
    .PROC_DATA(proc_data), .PROC_VALID(p_valid), .PROC_READY(p_ready),
`ifdef AUDIO_PASSTHRU_EN
    .BYPASS(bypass),
`endif
    .DROP_CNT(drop_cnt));

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (data_over) pulse_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exceeded, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (s_valid) begin n = i; break; end
    end
  endtask

  task automatic wait_pready(output int n);
    n = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (p_ready) begin n = i; break; end
    end
  endtask

  task automatic wait_pulse(input int p0, input int bound);
    for (int i = 0; i < bound && pulse_cnt == p0; i++) tick();
  endtask

  task automatic cleanup();
    adc_full = 1'b0; s_ready = 1'b0; p_valid = 1'b0; dac_full = 1'b0;
    repeat (S + 4) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    tests++; if (dac_out !== '0) begin fails++; $display("FAIL reset_dacdata: got %h expected 0", dac_out); end
    tests++; if (sample_out !== '0) begin fails++; $display("FAIL reset_sample_out: got %h expected 0", sample_out); end
    tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
    tests++; if (p_ready !== 1'b0) begin fails++; $display("FAIL reset_pready: got %b expected 0", p_ready); end
    tests++; if (data_over !== 1'b0) begin fails++; $display("FAIL reset_over: got %b expected 0", data_over); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    Reset = 1'b0;
  endtask

  task automatic test_init_hold();
    int any_valid = 0;
    int p0 = pulse_cnt;
    init_fin = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) begin adc_full = ~adc_full; adc_data = $urandom; end
      tick();
      if (s_valid || p_ready) any_valid++;
    end
    tests++; if (any_valid !== 0) begin fails++; $display("FAIL init_hold_valid: got %0d cycles active expected 0", any_valid); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL init_hold_drop: got %0d expected 0", drop_cnt); end
    tests++; if (sample_out !== '0) begin fails++; $display("FAIL init_hold_capture: got %h expected 0", sample_out); end
    tests++; if (pulse_cnt !== p0) begin fails++; $display("FAIL init_hold_pulse: got %0d expected %0d", pulse_cnt, p0); end
    adc_full = 1'b0; init_fin = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_basic_frame();
    int tv = -1, to = -1;
    int p0 = pulse_cnt;
    s_ready = 1'b1; p_valid = 1'b1; proc_data = 32'h0BAD_F00D; dac_full = 1'b0;
    adc_data = 32'h1234_ABCD; adc_full = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (tv < 0 && s_valid) tv = j;
      if (to < 0 && data_over) to = j;
    end
    exp_dac = 32'h0BAD_F00D;
    tests++; if (tv !== S + 2) begin fails++; $display("FAIL basic_valid_latency: got %0d expected %0d", tv, S + 2); end
    tests++; if (to !== S + 5) begin fails++; $display("FAIL basic_over_latency: got %0d expected %0d", to, S + 5); end
    tests++; if (sample_out !== 32'h1234_ABCD) begin fails++; $display("FAIL basic_sample_out: got %h expected 1234abcd", sample_out); end
    tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL basic_dacdata: got %h expected %h", dac_out, exp_dac); end
    tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL basic_pulses: got %0d expected 1", pulse_cnt - p0); end
    tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL basic_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    cleanup();
  endtask

  task automatic test_timeout_present();
    int n, cnt = 1;
    s_ready = 1'b0; adc_data = $urandom; adc_full = 1'b1;
    wait_valid(n);
    tests++; if (n < 0) begin fails++; $display("FAIL to_present_start: got no SAMPLE_VALID expected 1"); end
    else begin
      for (int i = 0; i < T + 20; i++) begin tick(); if (s_valid) cnt++; else break; end
      exp_drop++;
      tests++; if (cnt !== T) begin fails++; $display("FAIL to_present_cycles: got %0d expected %0d", cnt, T); end
      tests++; if (data_over !== 1'b1) begin fails++; $display("FAIL to_present_over: got %b expected 1", data_over); end
      tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL to_present_drop: got %0d expected %0d", drop_cnt, exp_drop); end
      tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL to_present_dac: got %h expected %h", dac_out, exp_dac); end
    end
    cleanup();
  endtask

  task automatic test_timeout_wait_proc();
    int n, cnt = 1;
    s_ready = 1'b1; p_valid = 1'b0; adc_data = $urandom; adc_full = 1'b1;
    wait_pready(n);
    tests++; if (n < 0) begin fails++; $display("FAIL to_wait_start: got no PROC_READY expected 1"); end
    else begin
      for (int i = 0; i < T + 20; i++) begin tick(); if (p_ready) cnt++; else break; end
      exp_drop++;
      tests++; if (cnt !== T) begin fails++; $display("FAIL to_wait_cycles: got %0d expected %0d", cnt, T); end
      tests++; if (data_over !== 1'b1) begin fails++; $display("FAIL to_wait_over: got %b expected 1", data_over); end
      tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL to_wait_drop: got %0d expected %0d", drop_cnt, exp_drop); end
      tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL to_wait_dac: got %h expected %h", dac_out, exp_dac); end
    end
    cleanup();
  endtask

  task automatic test_handshake_at_expiry();
    int n, p0;
    s_ready = 1'b0; adc_data = $urandom; adc_full = 1'b1;
    wait_valid(n);
    repeat (T - 1) tick();
    s_ready = 1'b1;
    p0 = pulse_cnt;
    tick();
    tests++; if (p_ready !== 1'b1) begin fails++; $display("FAIL expiry_hs_pready: got %b expected 1", p_ready); end
    tests++; if (data_over !== 1'b0) begin fails++; $display("FAIL expiry_hs_over: got %b expected 0", data_over); end
    tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL expiry_hs_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    proc_data = $urandom; p_valid = 1'b1; exp_dac = proc_data;
    wait_pulse(p0, 20);
    tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL expiry_hs_dac: got %h expected %h", dac_out, exp_dac); end
    cleanup();
  endtask

  task automatic test_overrun();
    int n, p0;
    logic [W-1:0] first = $urandom;
    s_ready = 1'b1; p_valid = 1'b0; adc_data = first; adc_full = 1'b1;
    wait_pready(n);
    adc_full = 1'b0; repeat (3) tick();
    adc_data = ~first; adc_full = 1'b1; repeat (S + 4) tick();
    exp_drop++;
    tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL overrun_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    tests++; if (p_ready !== 1'b1) begin fails++; $display("FAIL overrun_continues: got %b expected 1", p_ready); end
    p0 = pulse_cnt; proc_data = $urandom; p_valid = 1'b1; exp_dac = proc_data;
    wait_pulse(p0, 20);
    repeat (2) tick();
    tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL overrun_dac: got %h expected %h", dac_out, exp_dac); end
    tests++; if (sample_out !== first) begin fails++; $display("FAIL overrun_sample_kept: got %h expected %h", sample_out, first); end
    tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL overrun_pulses: got %0d expected 1", pulse_cnt - p0); end
    cleanup();
  endtask

  task automatic test_timeout_overrun();
    int n;
    s_ready = 1'b0; adc_data = $urandom; adc_full = 1'b1;
    wait_valid(n);
    adc_full = 1'b0;
    repeat (T - S - 2) tick();
    adc_full = 1'b1;
    for (int i = 0; i < S + 10 && s_valid; i++) tick();
    exp_drop = exp_drop + 16'd2;
    tests++; if (data_over !== 1'b1) begin fails++; $display("FAIL to_overrun_over: got %b expected 1", data_over); end
    tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL to_overrun_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    cleanup();
  endtask

  task automatic test_dac_busy();
    int n, p0, viol = 0;
    dac_full = 1'b1; repeat (S + 2) tick();
    s_ready = 1'b1; p_valid = 1'b1; proc_data = $urandom;
    adc_data = $urandom; adc_full = 1'b1;
    wait_valid(n);
    p0 = pulse_cnt;
    repeat (2) tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (dac_out !== exp_dac || data_over !== 1'b0) viol++;
    end
    tests++; if (viol !== 0) begin fails++; $display("FAIL dac_busy_hold: got %0d bad cycles expected 0", viol); end
    dac_full = 1'b0;
    exp_dac = proc_data;
    wait_pulse(p0, 12);
    repeat (3) tick();
    tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL dac_busy_load: got %h expected %h", dac_out, exp_dac); end
    tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL dac_busy_pulses: got %0d expected 1", pulse_cnt - p0); end
    cleanup();
  endtask

  task automatic test_init_drop();
    int n;
    int p0 = pulse_cnt;
    s_ready = 1'b0; adc_data = $urandom; adc_full = 1'b1;
    wait_valid(n);
    repeat (2) tick();
    init_fin = 1'b0;
    repeat (S) tick();
    tests++; if (s_valid !== 1'b1) begin fails++; $display("FAIL init_drop_early: got %b expected 1", s_valid); end
    tick();
    tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL init_drop_valid: got %b expected 0", s_valid); end
    tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL init_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
    tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL init_drop_dac: got %h expected %h", dac_out, exp_dac); end
    adc_full = 1'b0; repeat (5) tick();
    adc_full = 1'b1; repeat (8) tick();
    tests++; if (s_valid !== 1'b0 || pulse_cnt !== p0) begin fails++; $display("FAIL init_drop_stays: got valid %b pulses %0d expected 0 %0d", s_valid, pulse_cnt, p0); end
    init_fin = 1'b1; adc_full = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_frame();
    int n, p0;
    s_ready = 1'b1; p_valid = 1'b0; adc_data = $urandom; adc_full = 1'b1;
    wait_pready(n);
    p0 = pulse_cnt;
    Reset = 1'b1; adc_full = 1'b0;
    tick();
    Reset = 1'b0;
    exp_drop = 16'd0; exp_dac = '0;
    tests++; if (p_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_pready: got %b expected 0", p_ready); end
    tests++; if (drop_cnt !== 16'd0 || dac_out !== '0) begin fails++; $display("FAIL rst_mid_regs: got drop %0d dac %h expected 0 0", drop_cnt, dac_out); end
    repeat (6) tick();
    tests++; if (pulse_cnt !== p0) begin fails++; $display("FAIL rst_mid_pulse: got %0d expected %0d", pulse_cnt, p0); end
    cleanup();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 20; f++) begin
      int n, p0, rd, pv, db;
      logic [W-1:0] adc_v = $urandom;
      logic [W-1:0] proc_v = $urandom;
      logic ok;
      int sel = $urandom_range(0, 5);
      rd = (sel == 0) ? T : (sel == 1) ? T - 1 : $urandom_range(0, 8);
      sel = $urandom_range(0, 5);
      pv = (sel == 0) ? T : (sel == 1) ? T - 1 : $urandom_range(0, 8);
      db = $urandom_range(0, 12);
      dac_full = (db > 0); repeat (S + 1) tick();
      p0 = pulse_cnt;
      adc_data = adc_v; proc_data = proc_v; adc_full = 1'b1;
      wait_valid(n);
      tests++; if (n < 0) begin fails++; $display("FAIL rand_valid[%0d]: got no SAMPLE_VALID expected 1", f); end
      repeat (rd) tick();
      s_ready = 1'b1;
      ok = (rd < T);
      if (ok) begin
        tick();
        s_ready = 1'b0;
        tests++; if (p_ready !== 1'b1) begin fails++; $display("FAIL rand_pready[%0d]: got %b expected 1", f, p_ready); end
        repeat (pv) tick();
        p_valid = 1'b1;
        ok = (pv < T);
        if (ok) begin
          tick();
          p_valid = 1'b0;
          repeat (db) tick();
        end
      end
      dac_full = 1'b0;
      if (ok) exp_dac = proc_v; else exp_drop++;
      wait_pulse(p0, T + 30);
      repeat (2) tick();
      tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL rand_pulses[%0d]: got %0d expected 1", f, pulse_cnt - p0); end
      tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL rand_dac[%0d]: got %h expected %h", f, dac_out, exp_dac); end
      tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL rand_drop[%0d]: got %0d expected %0d", f, drop_cnt, exp_drop); end
      tests++; if (sample_out !== adc_v) begin fails++; $display("FAIL rand_sample[%0d]: got %h expected %h", f, sample_out, adc_v); end
      cleanup();
    end
  endtask

`ifdef AUDIO_PASSTHRU_EN
  task automatic test_bypass();
    int any_valid = 0;
    int p0 = pulse_cnt;
    bypass = 1'b1; s_ready = 1'b0; p_valid = 1'b0;
    adc_data = 32'h00FF_00FF; adc_full = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (s_valid) any_valid++; end
    exp_dac = 32'h00FF_00FF;
    tests++; if (any_valid !== 0) begin fails++; $display("FAIL bypass_valid: got %0d cycles expected 0", any_valid); end
    tests++; if (dac_out !== exp_dac) begin fails++; $display("FAIL bypass_dac: got %h expected %h", dac_out, exp_dac); end
    tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL bypass_pulses: got %0d expected 1", pulse_cnt - p0); end
    tests++; if (drop_cnt !== exp_drop) begin fails++; $display("FAIL bypass_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    bypass = 1'b0;
    cleanup();
  endtask
`endif

  initial begin
    test_reset();
    test_init_hold();
    test_basic_frame();
    test_timeout_present();
    test_timeout_wait_proc();
    test_handshake_at_expiry();
    test_overrun();
    test_timeout_overrun();
    test_dac_busy();
    test_init_drop();
    test_reset_mid_frame();
    test_random_frames();
`ifdef AUDIO_PASSTHRU_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
